// File: rtl/text_vga_pkg.sv
// ---------------------------------------------------------------------------
// text_vga_pkg
// Shared constants and types for the text-mode VGA scan-out block.
//   - 640x480@60 timing defaults (pixels / lines)
//   - glyph cell geometry (16x32, one 512-bit font word per glyph)
//   - screen geometry in cells, char memory base, cursor blink rate
//   - rgb_t : packed {R,G,B} colour
// Glyph geometry is fixed: the fetch pipeline forms the font bit index
// as {gy[4:0], gx[3:0]} directly, so GLYPH_W/GLYPH_H must stay 16/32.
// ---------------------------------------------------------------------------
package text_vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int GLYPH_W    = 16;
   localparam int GLYPH_H    = 32;
   localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

   localparam int COLS = VGA_H_ACTIVE / GLYPH_W;
   localparam int ROWS = VGA_V_ACTIVE / GLYPH_H;

   localparam logic [12:0] VGA_CHAR_BASE  = 13'd0;
   localparam int          VGA_BLINK_LOG2 = 5;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster counters and everything derived directly from them.
// Ports:
//   i_clk, i_rst_n   pixel clock, asynchronous active-low reset
//   o_col            character column (h / 16)
//   o_gx, o_gy       pixel position inside the current glyph cell
//   o_de             1 inside the active area
//   o_hsync/o_vsync  active-HIGH sync intervals (inverted at the pins)
//   o_frame_start    1 while the counters sit at (0,0); forced 0 in reset
//   o_row_base       cell index of column 0 of the current text row
//   o_blink          cursor blink phase (frame counter MSB)
// ---------------------------------------------------------------------------
module vga_timing_gen
   import text_vga_pkg::*;
#(
   parameter int H_ACTIVE   = VGA_H_ACTIVE,
   parameter int H_FP       = VGA_H_FP,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BP       = VGA_H_BP,
   parameter int V_ACTIVE   = VGA_V_ACTIVE,
   parameter int V_FP       = VGA_V_FP,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BP       = VGA_V_BP,
   parameter int BLINK_LOG2 = VGA_BLINK_LOG2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [5:0]  o_col,
   output logic [3:0]  o_gx,
   output logic [4:0]  o_gy,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_frame_start,
   output logic [12:0] o_row_base,
   output logic        o_blink
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int N_COLS  = H_ACTIVE / GLYPH_W;
   localparam int FCW     = BLINK_LOG2 + 1;

   logic [9:0]     r_h;
   logic [9:0]     r_v;
   logic [12:0]    r_row_base;
   logic [FCW-1:0] r_frame_cnt;
   logic           w_h_last;
   logic           w_v_last;

   assign w_h_last = (r_h == 10'(H_TOTAL - 1));
   assign w_v_last = (r_v == 10'(V_TOTAL - 1));

   // row_base is advanced by an adder instead of row*COLS so no multiplier
   // is needed; it steps when the last line of a glyph row ends.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h         <= '0;
         r_v         <= '0;
         r_row_base  <= '0;
         r_frame_cnt <= '0;
      end else if (w_h_last) begin
         r_h <= '0;
         if (w_v_last) begin
            r_v         <= '0;
            r_row_base  <= '0;
            r_frame_cnt <= r_frame_cnt + FCW'(1);
         end else begin
            r_v <= r_v + 10'd1;
            if (r_v[4:0] == 5'(GLYPH_H - 1))
               r_row_base <= r_row_base + 13'(N_COLS);
         end
      end else begin
         r_h <= r_h + 10'd1;
      end
   end

   assign o_col      = r_h[9:4];
   assign o_gx       = r_h[3:0];
   assign o_gy       = r_v[4:0];
   assign o_row_base = r_row_base;
   assign o_blink    = r_frame_cnt[BLINK_LOG2];
   assign o_de       = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
   assign o_hsync    = (r_h >= 10'(H_ACTIVE + H_FP)) &&
                       (r_h <  10'(H_ACTIVE + H_FP + H_SYNC));
   assign o_vsync    = (r_v >= 10'(V_ACTIVE + V_FP)) &&
                       (r_v <  10'(V_ACTIVE + V_FP + V_SYNC));
   // Counters idle at (0,0) during reset; gating with the reset keeps the
   // pulse quiet until the first real frame begins.
   assign o_frame_start = i_rst_n && (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: rtl/text_vga_renderer.sv
// ---------------------------------------------------------------------------
// text_vga_renderer
// Text-mode scan-out: char memory -> font memory -> pixel mux -> VGA DAC.
// Ports:
//   clk_clk, reset_reset_n        pixel clock, async active-low reset
//   char_rd_*                     char memory read port (1-cycle registered)
//   font_rd_*                     512-bit font memory read port (1-cycle)
//   cursor_addr, cursor_en        block cursor cell index / enable
//   fg_rgb, bg_rgb                colours, captured at frame_start
//   vga_r/g/b, vga_hs/vs,         DAC pins; syncs active low,
//   vga_blank_n, vga_sync_n       blank_n high only in the active area
//   frame_start                   pulse at counter (0,0)
// Latency from counter state to pins is 3 cycles:
//   S0 counters -> char address, S1 char data -> font address,
//   S2 font data -> pixel bit, S3 registered pins.
// ---------------------------------------------------------------------------
module text_vga_renderer
   import text_vga_pkg::*;
#(
   parameter int          H_ACTIVE   = VGA_H_ACTIVE,
   parameter int          H_FP       = VGA_H_FP,
   parameter int          H_SYNC     = VGA_H_SYNC,
   parameter int          H_BP       = VGA_H_BP,
   parameter int          V_ACTIVE   = VGA_V_ACTIVE,
   parameter int          V_FP       = VGA_V_FP,
   parameter int          V_SYNC     = VGA_V_SYNC,
   parameter int          V_BP       = VGA_V_BP,
   parameter logic [12:0] CHAR_BASE  = VGA_CHAR_BASE,
   parameter int          BLINK_LOG2 = VGA_BLINK_LOG2
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   output logic [12:0]           char_rd_address,
   output logic                  char_rd_chipselect,
   output logic                  char_rd_clken,
   output logic                  char_rd_write,
   input  logic [7:0]            char_rd_readdata,
   output logic [6:0]            font_rd_address,
   output logic                  font_rd_chipselect,
   output logic                  font_rd_clken,
   input  logic [GLYPH_BITS-1:0] font_rd_readdata,
   input  logic [12:0]           cursor_addr,
   input  logic                  cursor_en,
   input  logic [23:0]           fg_rgb,
   input  logic [23:0]           bg_rgb,
   output logic [7:0]            vga_r,
   output logic [7:0]            vga_g,
   output logic [7:0]            vga_b,
   output logic                  vga_hs,
   output logic                  vga_vs,
   output logic                  vga_blank_n,
   output logic                  vga_sync_n,
   output logic                  frame_start
);

   logic [5:0]  w_col;
   logic [3:0]  w_gx;
   logic [4:0]  w_gy;
   logic        w_de, w_hsync, w_vsync, w_frame_start, w_blink;
   logic [12:0] w_row_base;
   logic [12:0] w_cell;
   logic        w_hit;
   logic        w_bit;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .BLINK_LOG2(BLINK_LOG2)
   ) u_timing (
      .i_clk         (clk_clk),
      .i_rst_n       (reset_reset_n),
      .o_col         (w_col),
      .o_gx          (w_gx),
      .o_gy          (w_gy),
      .o_de          (w_de),
      .o_hsync       (w_hsync),
      .o_vsync       (w_vsync),
      .o_frame_start (w_frame_start),
      .o_row_base    (w_row_base),
      .o_blink       (w_blink)
   );

   // S0: the address is issued every pixel, blanking included.
   assign w_cell          = w_row_base + {7'd0, w_col};
   assign char_rd_address = CHAR_BASE + w_cell;
   assign w_hit           = (w_cell == cursor_addr);

   assign char_rd_chipselect = 1'b1;
   assign char_rd_clken      = 1'b1;
   assign char_rd_write      = 1'b0;
   assign font_rd_chipselect = 1'b1;
   assign font_rd_clken      = 1'b1;
   assign vga_sync_n         = 1'b0;
   assign frame_start        = w_frame_start;

   // S1: char data arrives one cycle after its address.
   assign font_rd_address = char_rd_readdata[6:0];

   rgb_t       r_fg, r_bg, r_rgb;
   logic [3:0] r1_gx, r2_gx;
   logic [4:0] r1_gy, r2_gy;
   logic       r1_de, r1_hs, r1_vs, r1_cur;
   logic       r2_de, r2_hs, r2_vs, r2_cur, r2_inv;
   logic       r_hs_n, r_vs_n, r_blank_n;

   // Colours only change on frame boundaries so a frame never mixes palettes.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_fg <= '0;
         r_bg <= '0;
      end else if (w_frame_start) begin
         r_fg <= fg_rgb;
         r_bg <= bg_rgb;
      end
   end

   // Syncs travel as active-high flags so cleared stages never pulse the pins.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r1_gx <= '0; r1_gy <= '0; r1_de <= 1'b0;
         r1_hs <= 1'b0; r1_vs <= 1'b0; r1_cur <= 1'b0;
         r2_gx <= '0; r2_gy <= '0; r2_de <= 1'b0;
         r2_hs <= 1'b0; r2_vs <= 1'b0; r2_cur <= 1'b0; r2_inv <= 1'b0;
         r_rgb <= '0; r_hs_n <= 1'b1; r_vs_n <= 1'b1; r_blank_n <= 1'b0;
      end else begin
         r1_gx  <= w_gx;
         r1_gy  <= w_gy;
         r1_de  <= w_de;
         r1_hs  <= w_hsync;
         r1_vs  <= w_vsync;
         r1_cur <= w_hit & cursor_en & w_blink;

         r2_gx  <= r1_gx;
         r2_gy  <= r1_gy;
         r2_de  <= r1_de;
         r2_hs  <= r1_hs;
         r2_vs  <= r1_vs;
         r2_cur <= r1_cur;
         r2_inv <= char_rd_readdata[7];

         r_rgb     <= r2_de ? (w_bit ? r_fg : r_bg) : '0;
         r_hs_n    <= ~r2_hs;
         r_vs_n    <= ~r2_vs;
         r_blank_n <= r2_de;
      end
   end

   // S2: inverse and cursor both XOR, so an inverse char under a visible
   // cursor reads as normal.
   assign w_bit = font_rd_readdata[{r2_gy, r2_gx}] ^ r2_inv ^ r2_cur;

   assign vga_r       = r_rgb.r;
   assign vga_g       = r_rgb.g;
   assign vga_b       = r_rgb.b;
   assign vga_hs      = r_hs_n;
   assign vga_vs      = r_vs_n;
   assign vga_blank_n = r_blank_n;

endmodule

// File: tb/tb_text_vga_renderer.sv
// ---------------------------------------------------------------------------
// tb_text_vga_renderer
// Directed bench on a shrunken raster (80x70 totals, 4x2 cells) so several
// frames fit in a short run. Cycle N_k = k-th falling edge after reset
// release; the pins at N_k show counter state k-3, state = v*80 + h.
// ---------------------------------------------------------------------------
module tb_text_vga_renderer;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 64, VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 80
   localparam int VT = VA + VF + VS + VB;   // 70
   localparam int FR = HT * VT;             // 5600

   localparam logic [23:0] FG0 = 24'hFF8000;
   localparam logic [23:0] FG1 = 24'h00FF00;
   localparam logic [23:0] BG  = 24'h0000FF;

   logic         clk, rst_n;
   logic [12:0]  char_rd_address;
   logic         char_rd_chipselect, char_rd_clken, char_rd_write;
   logic [7:0]   char_rd_readdata;
   logic [6:0]   font_rd_address;
   logic         font_rd_chipselect, font_rd_clken;
   logic [511:0] font_rd_readdata;
   logic [12:0]  cursor_addr;
   logic         cursor_en;
   logic [23:0]  fg_rgb, bg_rgb;
   logic [7:0]   vga_r, vga_g, vga_b;
   logic         vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
   logic [23:0]  pix;

   text_vga_renderer #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CHAR_BASE(13'd0), .BLINK_LOG2(1)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .char_rd_address(char_rd_address), .char_rd_chipselect(char_rd_chipselect),
      .char_rd_clken(char_rd_clken), .char_rd_write(char_rd_write),
      .char_rd_readdata(char_rd_readdata),
      .font_rd_address(font_rd_address), .font_rd_chipselect(font_rd_chipselect),
      .font_rd_clken(font_rd_clken), .font_rd_readdata(font_rd_readdata),
      .cursor_addr(cursor_addr), .cursor_en(cursor_en),
      .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .frame_start(frame_start)
   );

   assign pix = {vga_r, vga_g, vga_b};

   // ---- clock ----
   initial clk = 1'b0;
   always #20 clk = ~clk;

   // ---- memory models: registered reads, one cycle ----
   logic [7:0]   char_mem [0:8191];
   logic [511:0] font_mem [0:127];

   always @(posedge clk) begin
      char_rd_readdata <= char_mem[char_rd_address];
      font_rd_readdata <= font_mem[font_rd_address];
   end

   // ---- checking ----
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---- cycle tracking and first-frame pin statistics ----
   int   cyc;
   logic cnt_on;
   int   n_fs, n_hs, n_vs, n_de;

   task automatic acc();
      if (cnt_on && cyc < FR) begin
         if (frame_start === 1'b1) n_fs++;
         if (vga_hs === 1'b0)      n_hs++;
         if (vga_vs === 1'b0)      n_vs++;
         if (vga_blank_n === 1'b1) n_de++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      acc();
   endtask

   task automatic run_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic check_reset_pins(input string tag);
      check_eq({tag, "_hs"},    vga_hs, 1'b1);
      check_eq({tag, "_vs"},    vga_vs, 1'b1);
      check_eq({tag, "_blank"}, vga_blank_n, 1'b0);
      check_eq({tag, "_rgb"},   pix, 24'h0);
      check_eq({tag, "_fs"},    frame_start, 1'b0);
   endtask

   // ---- stimulus ----
   initial begin
      rst_n = 1'b0;
      fg_rgb = FG0;
      bg_rgb = BG;
      cursor_en = 1'b1;
      cursor_addr = 13'd0;
      cyc = 0; cnt_on = 1'b0;
      n_fs = 0; n_hs = 0; n_vs = 0; n_de = 0;
      for (int i = 0; i < 8192; i++) char_mem[i] = 8'h00;
      for (int i = 0; i < 128; i++)  font_mem[i] = '0;
      char_mem[0] = 8'h41;               // cell (0,0): 'A', normal
      char_mem[5] = 8'hC1;               // cell row1,col1: 'A', inverse
      font_mem[8'h41] = 512'h10005;      // bits 0,2,16 lit; bit 1 dark

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_pins("rst");
      check_eq("sync_n", vga_sync_n, 1'b0);
      check_eq("char_cs", {char_rd_chipselect, char_rd_clken, char_rd_write}, 3'b110);
      check_eq("font_cs", {font_rd_chipselect, font_rd_clken}, 2'b11);

      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      cyc = 0; cnt_on = 1'b1; acc();
      check_eq("fs_first", frame_start, 1'b1);
      check_eq("addr_cell0", char_rd_address, 13'd0);
      check_eq("fill_rgb", pix, 24'h0);
      run_to(1);  check_eq("font_addr0", font_rd_address, 7'h41);
      check_eq("fs_pulse", frame_start, 1'b0);
      run_to(3);  check_eq("px0_0", pix, FG0);
      check_eq("blank_on", vga_blank_n, 1'b1);
      run_to(4);  check_eq("px1_0", pix, BG);
      run_to(5);  check_eq("px2_0", pix, FG0);
      run_to(67); check_eq("hblank_rgb", pix, 24'h0);
      check_eq("hblank_n", vga_blank_n, 1'b0);
      run_to(70); check_eq("hs_before", vga_hs, 1'b1);
      run_to(71); check_eq("hs_first", vga_hs, 1'b0);
      run_to(78); check_eq("hs_last", vga_hs, 1'b0);
      run_to(79); check_eq("hs_after", vga_hs, 1'b1);
      run_to(83); check_eq("px0_1", pix, FG0);
      run_to(2576); check_eq("addr_cell5", char_rd_address, 13'd5);
      run_to(2577); check_eq("font_addr5", font_rd_address, 7'h41);
      run_to(2579); check_eq("inv_px16", pix, BG);
      run_to(2580); check_eq("inv_px17", pix, FG0);
      run_to(5282); check_eq("vs_before", vga_vs, 1'b1);
      run_to(5283); check_eq("vs_first", vga_vs, 1'b0);
      run_to(FR - 1);
      check_eq("cnt_fs", n_fs, 1);
      check_eq("cnt_hs", n_hs, HS * VT);
      check_eq("cnt_vs", n_vs, VS * HT);
      check_eq("cnt_de", n_de, HA * VA);
      cnt_on = 1'b0;

      // frame 1: cursor phase still off; fg changes mid-frame
      run_to(FR);     check_eq("fs_f1", frame_start, 1'b1);
      run_to(FR + 1); check_eq("fs_f1_end", frame_start, 1'b0);
      run_to(FR + 3); check_eq("f1_px0", pix, FG0);
      run_to(FR + 100); fg_rgb = FG1;
      run_to(FR + 2580); check_eq("fg_hold", pix, FG0);

      // frames 2,3: cursor on cell 0 visible; frame 4 back to normal
      run_to(2 * FR + 3);    check_eq("cur_f2_px0", pix, BG);
      run_to(2 * FR + 4);    check_eq("cur_f2_px1", pix, FG1);
      run_to(2 * FR + 2580); check_eq("fg_new", pix, FG1);
      run_to(3 * FR + 3);    check_eq("cur_f3_px0", pix, BG);
      run_to(4 * FR + 3);    check_eq("cur_f4_px0", pix, FG1);

      // mid-frame reset at v=40: pins show a lit inverse pixel just before
      run_to(4 * FR + 3220);
      check_eq("pre_rst_px", pix, FG1);
      rst_n = 1'b0;
      #1 check_reset_pins("rst_mid");
      repeat (3) @(negedge clk);
      check_reset_pins("rst_hold");
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      cyc = 0;
      check_eq("fs_restart", frame_start, 1'b1);
      check_eq("addr_restart", char_rd_address, 13'd0);
      check_eq("rgb_restart", pix, 24'h0);
      run_to(3);
      check_eq("px0_restart", pix, FG1);
      check_eq("blank_restart", vga_blank_n, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
